// File: rtl/aluout_pkg.sv
// Shared field layout of the packed ALU display word (A in the upper nibble, ~B in the lower).
// The transmit-side packer and this receiver both import it.
package aluout_pkg;

  localparam int unsigned WORD_W = 8;
  localparam int unsigned NIB_W  = 4;
  localparam int unsigned A_HI   = 7;
  localparam int unsigned A_LO   = 4;
  localparam int unsigned NB_HI  = 3;
  localparam int unsigned NB_LO  = 0;

  typedef struct packed {
    logic [NIB_W-1:0] a;
    logic [NIB_W-1:0] nb;
  } alu_word_t;

  function automatic logic [NIB_W-1:0] unpack_b(input logic [WORD_W-1:0] word);
    return ~word[NB_HI:NB_LO];
  endfunction

  function automatic logic [WORD_W-1:0] pack_word(input logic [NIB_W-1:0] a,
                                                  input logic [NIB_W-1:0] b);
    return {a, ~b};
  endfunction

endpackage

// File: rtl/aluout_unpack_word_fifo.sv
// Small ready/valid FIFO: storage, wrap-around pointers and occupancy-derived flags.
// Handshake outputs depend only on registered occupancy (no same-cycle pass-through).
module word_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 2
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             wr_valid,
  output logic             wr_ready,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned OCC_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic             push, pop;

  always_comb begin
    full     = (occ_q == OCC_W'(DEPTH));
    empty    = (occ_q == OCC_W'(0));
    wr_ready = !full;
    rd_valid = !empty;
    rd_data  = mem_q[rd_ptr_q];
  end

  // Pointer and occupancy update; DEPTH is a power of two so pointers wrap naturally.
  always_comb begin
    push     = wr_valid && wr_ready;
    pop      = rd_valid && rd_ready;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (push && !pop)      occ_d = occ_q + OCC_W'(1);
    else if (pop && !push) occ_d = occ_q - OCC_W'(1);
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  // Storage is not reset; stale entries are masked by occupancy.
  always_ff @(posedge Clock) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/aluout_unpack.sv
// Receive side of the packed ALU display word: buffers words, recovers A and B from the head
// entry and counts delivered words.
module aluout_unpack
  import aluout_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = 8
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [3:0]        out_a,
  output logic [3:0]        out_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  word_count,
  output logic              full,
  output logic              empty
);

  logic [WORD_W-1:0] head_word;
  alu_word_t         head;
  logic [CNT_W-1:0]  word_count_q, word_count_d;

  word_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .Clock    (Clock),
    .Resetn   (Resetn),
    .wr_data  (in_data),
    .wr_valid (in_valid),
    .wr_ready (in_ready),
    .rd_data  (head_word),
    .rd_valid (out_valid),
    .rd_ready (out_ready),
    .full     (full),
    .empty    (empty)
  );

  // Decode the head entry; force zero when empty so stale storage never shows.
  always_comb begin
    head  = alu_word_t'(head_word);
    out_a = '0;
    out_b = '0;
    if (!empty) begin
      out_a = head.a;
      out_b = unpack_b(head_word);
    end
  end

  always_comb begin
    word_count_d = word_count_q;
    if (out_valid && out_ready) word_count_d = word_count_q + CNT_W'(1);
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) word_count_q <= '0;
    else         word_count_q <= word_count_d;
  end

  assign word_count = word_count_q;

endmodule
